// File: rtl/ah_demux_pkg.sv
// Shared types and default sizing for the AH demux family.
// The route stage and the demux both size themselves from these defaults.
package ah_demux_pkg;

  localparam int AH_DATA_W  = 9;
  localparam int AH_NUM_EGR = 18;
  localparam int AH_SEL_W   = 5;

  // Buffer entry at the family's default widths.
  typedef struct packed {
    logic [AH_DATA_W-1:0] data;
    logic                 last;
    logic [AH_SEL_W-1:0]  sel;
  } ah_entry_t;

  typedef enum logic [1:0] {
    HEAD = 2'd0,
    BODY = 2'd1,
    DROP = 2'd2
  } route_state_e;

endpackage

// File: rtl/ah_skid_buf2.sv
// Generic 2-entry valid/ready skid buffer with a registered in_ready.
// Output is always driven from the head entry, so it holds steady under back-pressure.
module ah_skid_buf2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic [1:0]   count_next;
  logic         push;
  logic         pop;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];

  always_comb begin
    count_next = count + {1'b0, push} - {1'b0, pop};
  end

  // NOTE: the two entries are reset because out_data is read straight from
  // them and must come out of reset as zero; larger memories would not be reset.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      in_ready <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count    <= count_next;
      // Ready for the next cycle depends only on net occupancy, never on out_ready directly.
      in_ready <= (count_next != 2'd2);
    end
  end

endmodule

// File: rtl/ah_demux_route_stage.sv
// Decodes the egress index from each packet's head beat, tags every beat with it,
// and feeds the demux through a 2-entry skid buffer; out-of-range packets are discarded.
module ah_demux_route_stage
  import ah_demux_pkg::*;
#(
  parameter int DATA_W   = AH_DATA_W,
  parameter int NUM_EGR  = AH_NUM_EGR,
  parameter int SEL_W    = AH_SEL_W,
  parameter int DEST_LSB = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SEL_W-1:0]  out_select,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              drop_pulse
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [SEL_W-1:0]  sel;
  } entry_t;

  localparam int PAYLOAD_W = $bits(entry_t);

  route_state_e     state;
  route_state_e     state_next;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] dest;
  logic             dest_ok;
  logic             accept;
  logic             push_valid;
  logic             drop_start;
  logic             buf_in_ready;
  entry_t           push_entry;
  entry_t           head_entry;

  assign dest    = in_data[DEST_LSB +: SEL_W];
  assign dest_ok = ({{(32-SEL_W){1'b0}}, dest} < 32'(NUM_EGR));

  // While discarding, beats are swallowed regardless of buffer occupancy.
  assign in_ready = (state == DROP) | buf_in_ready;
  assign accept   = in_valid & in_ready;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    push_valid = 1'b0;
    drop_start = 1'b0;
    push_entry = '{data: in_data, last: in_last, sel: sel_q};
    case (state)
      HEAD: begin
        push_entry.sel = dest;
        push_valid     = in_valid & dest_ok;
        if (accept) begin
          drop_start = ~dest_ok;
          if (!in_last) state_next = dest_ok ? BODY : DROP;
        end
      end
      BODY: begin
        push_valid = in_valid;
        if (accept && in_last) state_next = HEAD;
      end
      DROP: begin
        if (accept && in_last) state_next = HEAD;
      end
      default: state_next = HEAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HEAD;
      sel_q      <= '0;
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_next;
      drop_pulse <= drop_start;
      if (accept && state == HEAD && dest_ok) sel_q <= dest;
      if (drop_start && drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  ah_skid_buf2 #(
    .W(PAYLOAD_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   (push_entry),
    .in_valid  (push_valid),
    .in_ready  (buf_in_ready),
    .out_data  (head_entry),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Select comes from the buffered entry so it cannot change under a stalled beat.
  assign out_data   = head_entry.data;
  assign out_last   = head_entry.last;
  assign out_select = head_entry.sel;

endmodule
